// File: rtl/coax_rx_bit_timer.sv
// Receive bit timer / Manchester decoder for the 3270 coax line.
// Locks onto mid-bit transitions and emits one decoded bit per bit period.
module coax_rx_bit_timer #(
  parameter int CLOCKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic bit_strobe,
  output logic bit_value,
  output logic locked,
  output logic error
);

  localparam int WIN_MIN = 3 * CLOCKS_PER_BIT / 4;
  localparam int WIN_MAX = 5 * CLOCKS_PER_BIT / 4;
  localparam int CW      = $clog2(WIN_MAX + 2);

  localparam logic [CW-1:0] CNT_MIN     = CW'(WIN_MIN);
  localparam logic [CW-1:0] CNT_TIMEOUT = CW'(WIN_MAX + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          rx_prev;
  logic          edge_det;
  logic          strobe_n, value_n, error_n;

  assign edge_det = (rx != rx_prev);
  assign locked   = (state == TRACK);

  // cnt holds d for the current cycle: the accepting edge is d=0, so the
  // cycle after it is d=1. That keeps an ideal mid edge at exactly d=CLOCKS_PER_BIT.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    strobe_n = 1'b0;
    error_n  = 1'b0;
    value_n  = bit_value;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (edge_det) begin
          state_n = TRACK;
          cnt_n   = CW'(1);
        end
      end
      TRACK: begin
        // Timeout beats a coincident edge; cnt can never pass CNT_TIMEOUT.
        if (cnt == CNT_TIMEOUT) begin
          error_n = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else if (edge_det && cnt >= CNT_MIN) begin
          strobe_n = 1'b1;
          value_n  = rx;
          cnt_n    = CW'(1);
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    rx_prev <= rx;
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_strobe <= 1'b0;
      bit_value  <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_strobe <= strobe_n;
      bit_value  <= value_n;
      error      <= error_n;
    end
  end

endmodule

// File: tb/tb_coax_rx_bit_timer.sv
// Bench for coax_rx_bit_timer: table-driven edge gaps, directed corner
// sequences, then random line activity against a timestamp-based model.
module tb_coax_rx_bit_timer;

  localparam int CPB     = 8;
  localparam int WIN_MIN = 6;
  localparam int WIN_MAX = 10;

  logic clk = 1'b0;
  logic reset, rx;
  logic bit_strobe, bit_value, locked, error;

  int checks = 0;
  int errors = 0;

  coax_rx_bit_timer #(.CLOCKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .bit_strobe(bit_strobe), .bit_value(bit_value),
    .locked(locked), .error(error)
  );

  always #5 clk = ~clk;

  // Reference model: remembers the cycle number of the last accepted edge
  // and judges each new edge by its distance from that timestamp.
  int  n = 0;
  int  m_last = 0;
  bit  m_lock = 0, m_prev = 1, m_val = 0, m_strobe = 0, m_err = 0;
  bit  use_model = 0;
  bit  cur = 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, n, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit x);
    int d;
    @(negedge clk);
    reset = r;
    rx    = x;
    @(posedge clk);
    #1;
    n++;
    m_strobe = 0;
    m_err    = 0;
    if (r) begin
      m_lock = 0;
      m_val  = 0;
    end else if (m_lock) begin
      d = n - m_last;
      if (d == WIN_MAX + 1) begin
        m_err  = 1;
        m_lock = 0;
      end else if (x != m_prev && d >= WIN_MIN && d <= WIN_MAX) begin
        m_strobe = 1;
        m_val    = x;
        m_last   = n;
      end
    end else if (x != m_prev) begin
      m_lock = 1;
      m_last = n;
    end
    m_prev = x;
    if (use_model) begin
      chk("model_strobe", 32'(bit_strobe), 32'(m_strobe));
      chk("model_value",  32'(bit_value),  32'(m_val));
      chk("model_locked", 32'(locked),     32'(m_lock));
      chk("model_error",  32'(error),      32'(m_err));
    end
  endtask

  // Hold the line for g-1 cycles then toggle, so the toggle lands g cycles
  // after the previous one; check quiet in between and outputs after it.
  task automatic gap_rec(input int g, input bit es, input bit ev, input bit el, input bit ee);
    for (int i = 1; i < g; i++) begin
      step(0, cur);
      chk("gap_no_strobe", 32'(bit_strobe), 0);
      chk("gap_no_error",  32'(error), 0);
    end
    cur = ~cur;
    step(0, cur);
    chk("edge_strobe", 32'(bit_strobe), 32'(es));
    chk("edge_value",  32'(bit_value),  32'(ev));
    chk("edge_locked", 32'(locked),     32'(el));
    chk("edge_error",  32'(error),      32'(ee));
  endtask

  typedef struct {
    int gap;
    bit s;
    bit v;
    bit l;
    bit e;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // gap, strobe, value, locked, error
    tbl[0]  = '{5,  0, 0, 1, 0};  // lock edge, no strobe
    tbl[1]  = '{8,  1, 1, 1, 0};  // bit 1
    tbl[2]  = '{8,  1, 0, 1, 0};  // bit 0
    tbl[3]  = '{8,  1, 1, 1, 0};  // bit 1
    tbl[4]  = '{4,  0, 1, 1, 0};  // boundary edge of next bit 1
    tbl[5]  = '{4,  1, 1, 1, 0};  // bit 1
    tbl[6]  = '{8,  1, 0, 1, 0};  // bit 0
    tbl[7]  = '{6,  1, 1, 1, 0};  // early edge at window min
    tbl[8]  = '{10, 1, 0, 1, 0};  // late edge at window max
    tbl[9]  = '{5,  0, 0, 1, 0};  // d=5 ignored
    tbl[10] = '{3,  1, 0, 1, 0};  // d=8 accepted
    tbl[11] = '{11, 0, 0, 0, 1};  // edge at d=11: timeout wins
    tbl[12] = '{3,  0, 0, 1, 0};  // relock, no strobe
    tbl[13] = '{8,  1, 1, 1, 0};  // first strobe after relock

    // Reset with rx held high, then 20 idle cycles.
    cur = 1;
    for (int i = 0; i < 3; i++) step(1, cur);
    chk("reset_strobe", 32'(bit_strobe), 0);
    chk("reset_value",  32'(bit_value), 0);
    chk("reset_locked", 32'(locked), 0);
    chk("reset_error",  32'(error), 0);
    for (int i = 0; i < 20; i++) begin
      step(0, cur);
      chk("idle_outputs", {28'd0, bit_strobe, bit_value, locked, error}, 0);
    end

    foreach (tbl[i]) gap_rec(tbl[i].gap, tbl[i].s, tbl[i].v, tbl[i].l, tbl[i].e);

    // Line goes quiet after an accepted edge: single error at d=11.
    for (int i = 1; i <= 12; i++) begin
      step(0, cur);
      chk("quiet_strobe", 32'(bit_strobe), 0);
      chk("quiet_error",  32'(error),  32'(i == 11));
      chk("quiet_locked", 32'(locked), 32'(i < 11));
    end

    // Reset pulse while tracking mid-bit.
    gap_rec(4, 0, 1, 1, 0);
    gap_rec(8, 1, !cur, 1, 0);
    for (int i = 0; i < 4; i++) step(0, cur);
    step(1, cur);
    chk("midreset_outputs", {28'd0, bit_strobe, bit_value, locked, error}, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, cur);
      chk("post_reset_quiet", {28'd0, bit_strobe, locked, error}, 0);
    end
    gap_rec(1, 0, 0, 1, 0);
    gap_rec(8, 1, !cur, 1, 0);

    // Random line activity, biased toward Manchester-like gaps.
    step(1, cur);
    use_model = 1;
    for (int k = 0; k < 400; k++) begin
      int r, g;
      r = int'($urandom_range(0, 9));
      if (r < 4)      g = 8;
      else if (r < 6) g = 4;
      else            g = int'($urandom_range(1, 13));
      for (int i = 1; i < g; i++) step($urandom_range(0, 299) == 0, cur);
      cur = ~cur;
      step(0, cur);
    end
    use_model = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/coax_rx_bit_timer.md
# coax_rx_bit_timer

Receive-side bit timer and Manchester bit decoder for the 3270 coax interface. It is the counterpart of the transmit `coax_bit_timer`. It takes the already-synchronized receive line, locks onto mid-bit transitions, tolerates timing jitter within a window, and emits one decoded bit per bit period. It sits between the input synchronizer and the receive word/framing logic, and flags loss of lock when an expected mid-bit transition does not arrive.

## Interface

Parameters:
- `CLOCKS_PER_BIT`, default 8: clk cycles per coax bit period; must be ≥ 8 and divisible by 4.

Ports:
- `clk` input 1: system clock, single clock domain.
- `reset` input 1: synchronous, active-high reset.
- `rx` input 1: receive line level, already synchronized to `clk` outside this block.
- `bit_strobe` output 1: one-cycle pulse; a decoded bit is valid on `bit_value`.
- `bit_value` output 1: decoded bit, equal to the `rx` level after the mid-bit transition. Held until the next strobe.
- `locked` output 1: high while tracking mid-bit transitions.
- `error` output 1: one-cycle pulse when the expected mid-bit transition is missing.

## Operation

- Edge detect: `rx_prev` is registered every cycle. An edge is flagged when `rx != rx_prev`. During reset, `rx_prev` loads `rx`, so no spurious edge occurs at reset release.
- Local constants:
  - `WIN_MIN = 3*CLOCKS_PER_BIT/4` (6 at default).
  - `WIN_MAX = 5*CLOCKS_PER_BIT/4` (10 at default).
  - Counter width is clog2(WIN_MAX+2).
- `d` is the number of clk cycles since the last accepted edge.
- States:
  - IDLE: `locked`=0 and the counter is held at 0.
    - Any edge → TRACK, counter restarts, `d`=0. No strobe is issued, because the first edge only establishes phase.
  - TRACK: `locked`=1.
    - Edge with `d` < `WIN_MIN`: ignored as a bit-boundary transition; the counter continues.
    - Edge with `WIN_MIN` ≤ `d` ≤ `WIN_MAX`: accepted as mid-bit. `bit_strobe` pulses, `bit_value` takes the new `rx` level, and `d` restarts at 0.
    - `d` reaches `WIN_MAX+1` without an accepted edge: `error` pulses, `locked` falls, and the state returns to IDLE.
- Simultaneous timeout and edge at `d = WIN_MAX+1`: the timeout wins. `error` pulses, the edge is discarded, and IDLE relocks on the next edge.
- False lock on a boundary edge is recovered by design. The first bit change produces a mid edge at `d = CLOCKS_PER_BIT + CLOCKS_PER_BIT/2`, which exceeds `WIN_MAX`, so a timeout fires and the block relocks. Framing logic must discard data until its own sync pattern is seen.
- The counter never wraps: it is bounded by the timeout at `WIN_MAX+1`.

## Timing

- Reset values: `bit_strobe`=0, `bit_value`=0, `locked`=0, `error`=0, state IDLE, counter 0.
- All outputs are registered.
- Latency is one cycle. If `rx` takes a new level at posedge k, `bit_strobe`/`bit_value` (or the IDLE→TRACK `locked` rise) are visible after posedge k+1.
- `bit_strobe` and `error` are never high in the same cycle, and each is high for exactly one cycle.
- With an ideal stream, strobes are exactly `CLOCKS_PER_BIT` cycles apart.
- Reset asserted mid-bit: outputs return to reset values after that posedge. No strobe or error is produced for the interrupted bit.
- No handshake: downstream must sample on `bit_strobe`.

## Structure

- No shared package is needed.
- `WIN_MIN`, `WIN_MAX` and the state encodings (IDLE, TRACK) are localparams derived from `CLOCKS_PER_BIT` inside the module.
- Single module, with no sub-module. Edge detect is a trivial register plus compare.

## Test plan

All scenarios use `CLOCKS_PER_BIT`=8.

1. Hold `rx`=1 through reset and for 20 cycles after release → all outputs stay 0; no strobe, no error.
2. A lock edge, then ideal Manchester bits 1,0,1,1,0 → five strobes spaced exactly 8 cycles apart, `bit_value` sequence 1,0,1,1,0, and `locked`=1 throughout.
3. Jittered mid edges:
   - At `d`=6 and at `d`=10 → both accepted.
   - An edge at `d`=5 → ignored, no strobe; the following edge at `d`=8 is accepted.
4. `rx` stops toggling after an accepted edge → `error` pulses once at `d`=11 and `locked` falls in the same cycle; there are no further strobes.
5. Edge arrives exactly at `d`=11 → `error` pulses and the edge is discarded. The next edge relocks (`locked`=1) with no strobe; the edge after that at `d`=8 gives a strobe.
6. One-cycle `reset` pulse in TRACK mid-bit → outputs reset the next cycle; no strobe until a fresh lock edge plus an accepted mid edge.
